axi_burst_packer: RTL and testbench

Write-side initiator that is the inverse of the AW beat-address counter: accepts a backpressurable stream of individual (address, data) beats and coalesces contiguous ones into AXI4 INCR write bursts on the AW/W channels, then collects the B response. Sits between a beat-producing datapath and an AXI4 write slave. One burst outstanding at a time.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/axi_burst_packer.sv | 170 +++++++++++++++++
 tb/tb_axi_burst_packer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and packer state type for the write-burst coalescer.
package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam int         ADDR_INCR  = 4;

    typedef enum logic [1:0] {
        COLLECT,
        SEND_AW,
        SEND_W,
        WAIT_B
    } state_e;

    // AxSIZE is log2 of the bytes moved per beat.
    function automatic logic [2:0] axSize(input int bytes);
        axSize = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) axSize = 3'(i);
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding the beats of the burst currently being built or drained.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 36
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush, doPop;

    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= wdata_i;
    end

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
            if (doPush && !doPop)      count_q <= count_q + 1'b1;
            else if (doPop && !doPush) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/axi_burst_packer.sv
// Coalesces contiguous (address, data) beats into AXI4 INCR write bursts,
// one burst outstanding, and records any non-OKAY write response.
module axi_burst_packer
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    parameter int IDLE_FLUSH = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ADDR_WIDTH-1:0]   i_beat_addr,
    input  logic [DATA_WIDTH-1:0]   i_beat_data,
    input  logic [DATA_WIDTH/8-1:0] i_beat_strb,
    input  logic                    i_beat_valid,
    output logic                    i_beat_ready,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic [7:0]              o_awlen,
    output logic [2:0]              o_awsize,
    output logic [1:0]              o_awburst,
    output logic                    o_awvalid,
    input  logic                    o_awready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wlast,
    output logic                    o_wvalid,
    input  logic                    o_wready,
    input  logic [1:0]              i_bresp,
    input  logic                    i_bvalid,
    output logic                    i_bready,
    output logic                    o_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int FIFO_W = DATA_WIDTH + STRB_W;
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);
    localparam int IDLE_W = $clog2(IDLE_FLUSH + 1);
    localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0]      ONE_CNT   = CNT_W'(1);
    localparam logic [IDLE_W-1:0]     IDLE_MAX  = IDLE_W'(IDLE_FLUSH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(ADDR_INCR);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   baseAddr_q, nextAddr_q, awAddr_q;
    logic [7:0]              awLen_q;
    logic [IDLE_W-1:0]       idleCnt_q;
    logic                    awValid_q, wValid_q, bReady_q, err_q;

    logic [CNT_W-1:0]        count;
    logic [FIFO_W-1:0]       fifoHead;
    logic                    fifoFull, fifoEmpty;
    logic                    wrapHit, contiguous, beatAccept, closeBurst, wPop;

    sync_fifo #(
        .DEPTH (MAX_BEATS),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (beatAccept),
        .pop_i   (wPop),
        .wdata_i ({i_beat_strb, i_beat_data}),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (count)
    );

    // A buffered beat at the top of the address space must not be extended past the wrap.
    assign wrapHit      = (count != '0) && (nextAddr_q == '0);
    assign contiguous   = (count == '0) || (i_beat_addr == nextAddr_q);
    assign i_beat_ready = resetn && (state_q == COLLECT) && (count < MAX_CNT) && contiguous && !wrapHit;
    assign beatAccept   = i_beat_valid && i_beat_ready;
    assign wPop         = wValid_q && o_wready;
    assign closeBurst   = (state_q == COLLECT) && (count != '0) &&
                          ((count == MAX_CNT) || (i_beat_valid && !contiguous) || wrapHit ||
                           (!i_beat_valid && idleCnt_q == IDLE_MAX));

    assign o_awaddr  = awAddr_q;
    assign o_awlen   = awLen_q;
    assign o_awsize  = axSize(STRB_W);
    assign o_awburst = BURST_INCR;
    assign o_awvalid = awValid_q;
    assign o_wvalid  = wValid_q;
    assign o_wdata   = wValid_q ? fifoHead[DATA_WIDTH-1:0] : '0;
    assign o_wstrb   = wValid_q ? fifoHead[FIFO_W-1:DATA_WIDTH] : '0;
    assign o_wlast   = wValid_q && (count == ONE_CNT);
    assign i_bready  = bReady_q;
    assign o_err     = err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= COLLECT;
            baseAddr_q <= '0;
            nextAddr_q <= '0;
            awAddr_q   <= '0;
            awLen_q    <= '0;
            idleCnt_q  <= '0;
            awValid_q  <= 1'b0;
            wValid_q   <= 1'b0;
            bReady_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (beatAccept) begin
                if (count == '0) baseAddr_q <= i_beat_addr;
                nextAddr_q <= i_beat_addr + ADDR_STEP;
            end
            if (beatAccept || count == '0 || state_q != COLLECT) idleCnt_q <= '0;
            else if (!i_beat_valid) idleCnt_q <= idleCnt_q + 1'b1;

            case (state_q)
                COLLECT: if (closeBurst) begin
                    state_q   <= SEND_AW;
                    awValid_q <= 1'b1;
                    awAddr_q  <= baseAddr_q;
                    awLen_q   <= 8'(count - 1'b1);
                end
                SEND_AW: if (o_awready) begin
                    state_q   <= SEND_W;
                    awValid_q <= 1'b0;
                    wValid_q  <= 1'b1;
                end
                SEND_W: if (wPop && count == ONE_CNT) begin
                    state_q  <= WAIT_B;
                    wValid_q <= 1'b0;
                    bReady_q <= 1'b1;
                end
                WAIT_B: if (i_bvalid) begin
                    state_q  <= COLLECT;
                    bReady_q <= 1'b0;
                    if (i_bresp != RESP_OKAY) err_q <= 1'b1;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn && i_beat_valid) assert (i_beat_addr[1:0] == 2'b00);
        if (resetn) assert (!(beatAccept && fifoFull) && !(wPop && fifoEmpty));
    end
`endif

`ifdef FORMAL
    logic [8:0]            fBeats_q;
    logic [ADDR_WIDTH+9:0] fEnd;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) fBeats_q <= '0;
        else if (o_awvalid && o_awready) fBeats_q <= '0;
        else if (wPop) fBeats_q <= fBeats_q + 9'd1;
    end

    assign fEnd = (ADDR_WIDTH+10)'(o_awaddr) + ((ADDR_WIDTH+10)'(o_awlen) + 1) * ADDR_INCR;

    assume property (@(posedge clk) disable iff (!resetn)
        i_bvalid && !i_bready |=> i_bvalid && $stable(i_bresp));
    assert property (@(posedge clk) disable iff (!resetn)
        o_awvalid && !o_awready |=> o_awvalid && $stable(o_awaddr) && $stable(o_awlen));
    assert property (@(posedge clk) disable iff (!resetn)
        o_wvalid && !o_wready |=> o_wvalid && $stable(o_wdata) && $stable(o_wstrb) && $stable(o_wlast));
    assert property (@(posedge clk) disable iff (!resetn)
        wPop && o_wlast |-> fBeats_q == {1'b0, o_awlen});
    assert property (@(posedge clk) disable iff (!resetn)
        o_awvalid |-> fEnd <= (ADDR_WIDTH+10)'(2**ADDR_WIDTH));
`endif

endmodule

// File: tb/tb_axi_burst_packer.sv
// Directed bench: beat table with expected burst placement, random slave stalls,
// plus error-response and mid-burst reset sequences.
module tb_axi_burst_packer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] i_beat_addr;
    logic [31:0] i_beat_data;
    logic [3:0]  i_beat_strb;
    logic        i_beat_valid;
    logic        i_beat_ready;
    logic [11:0] o_awaddr;
    logic [7:0]  o_awlen;
    logic [2:0]  o_awsize;
    logic [1:0]  o_awburst;
    logic        o_awvalid, o_awready;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_wlast, o_wvalid, o_wready;
    logic [1:0]  i_bresp;
    logic        i_bvalid, i_bready;
    logic        o_err;

    always #5 clk = ~clk;

    axi_burst_packer #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32),
        .MAX_BEATS  (16),
        .IDLE_FLUSH (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_beat_addr  (i_beat_addr),
        .i_beat_data  (i_beat_data),
        .i_beat_strb  (i_beat_strb),
        .i_beat_valid (i_beat_valid),
        .i_beat_ready (i_beat_ready),
        .o_awaddr     (o_awaddr),
        .o_awlen      (o_awlen),
        .o_awsize     (o_awsize),
        .o_awburst    (o_awburst),
        .o_awvalid    (o_awvalid),
        .o_awready    (o_awready),
        .o_wdata      (o_wdata),
        .o_wstrb      (o_wstrb),
        .o_wlast      (o_wlast),
        .o_wvalid     (o_wvalid),
        .o_wready     (o_wready),
        .i_bresp      (i_bresp),
        .i_bvalid     (i_bvalid),
        .i_bready     (i_bready),
        .o_err        (o_err)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [11:0] expAw;
        logic [7:0]  expLen;
        logic        expLast;
        int          idleAfter;
        bit          expStall;
        bit          zeroWait;
    } vec_t;

    typedef struct {
        logic [11:0] aw;
        logic [7:0]  len;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } wrec_t;

    vec_t        vecs[$];
    wrec_t       wQ[$];
    logic [11:0] awAddrQ[$];
    logic [7:0]  awLenQ[$];

    int compared   = 0;
    int mismatched = 0;
    int bDone      = 0;
    int errIdx     = 6;
    bit bPending   = 1'b0;
    bit holdW      = 1'b0;

    bit          awStall = 1'b0, wStall = 1'b0;
    logic [11:0] savedAw;
    logic [7:0]  savedLen;
    logic [31:0] savedData;
    logic [3:0]  savedStrb;
    logic        savedLast;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic [11:0] a, input logic [11:0] aw, input logic [7:0] len,
                                   input bit last, input int idle, input bit stall, input bit zero);
        vec_t v;
        v.addr      = a;
        v.data      = 32'hD000_0000 | 32'(vecs.size() << 16) | {20'h0, a};
        v.strb      = 4'((vecs.size() % 15) + 1);
        v.expAw     = aw;
        v.expLen    = len;
        v.expLast   = last;
        v.idleAfter = idle;
        v.expStall  = stall;
        v.zeroWait  = zero;
        return v;
    endfunction

    function automatic void addVec(input logic [11:0] a, input logic [11:0] aw, input logic [7:0] len,
                                   input bit last, input int idle, input bit stall, input bit zero);
        vecs.push_back(mkVec(a, aw, len, last, idle, stall, zero));
    endfunction

    // Present one beat, hold it until accepted, then optionally go idle.
    task automatic applyStimulus(input vec_t v, input string tag);
        int waitCyc = 0;
        int bBefore;
        @(negedge clk);
        i_beat_valid = 1'b1;
        i_beat_addr  = v.addr;
        i_beat_data  = v.data;
        i_beat_strb  = v.strb;
        #1;
        bBefore = bDone;
        while (!i_beat_ready && waitCyc < 500) begin
            @(negedge clk);
            #1;
            waitCyc++;
        end
        if (!i_beat_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_accept_timeout: got ready 0 after %0d cycles, expected ready 1", tag, waitCyc);
            i_beat_valid = 1'b0;
            return;
        end
        if (v.zeroWait) checkOutput({tag, "_zero_bubble"}, waitCyc, 0);
        if (v.expStall) begin
            checkOutput({tag, "_stalled"}, (waitCyc > 0) ? 1 : 0, 1);
            checkOutput({tag, "_released_by_b"}, bDone - bBefore, 1);
            checkOutput({tag, "_err_so_far"}, o_err, (bDone > errIdx) ? 1 : 0);
        end
        @(posedge clk);
        if (v.idleAfter > 0) begin
            @(negedge clk);
            i_beat_valid = 1'b0;
            repeat (v.idleAfter - 1) @(negedge clk);
        end
    endtask

    // Slave model: random stalls, handshake capture and stall-stability checks.
    initial begin
        o_awready = 1'b0;
        o_wready  = 1'b0;
        i_bvalid  = 1'b0;
        i_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            o_awready = ($urandom_range(0, 3) != 0);
            o_wready  = !holdW && ($urandom_range(0, 3) != 0);
            i_bvalid  = bPending;
            i_bresp   = (bDone == errIdx) ? 2'b10 : 2'b00;
            #1;
            if (!resetn) begin
                awStall = 1'b0;
                wStall  = 1'b0;
            end else begin
                if (awStall) begin
                    checkOutput("aw_hold_valid", o_awvalid, 1);
                    checkOutput("aw_hold_addr", o_awaddr, savedAw);
                    checkOutput("aw_hold_len", o_awlen, savedLen);
                end
                if (wStall) begin
                    checkOutput("w_hold_valid", o_wvalid, 1);
                    checkOutput("w_hold_data", o_wdata, savedData);
                    checkOutput("w_hold_strb", o_wstrb, savedStrb);
                    checkOutput("w_hold_last", o_wlast, savedLast);
                end
                awStall   = o_awvalid && !o_awready;
                wStall    = o_wvalid && !o_wready;
                savedAw   = o_awaddr;
                savedLen  = o_awlen;
                savedData = o_wdata;
                savedStrb = o_wstrb;
                savedLast = o_wlast;
                if (o_awvalid && o_awready) begin
                    checkOutput("awsize", o_awsize, 2);
                    checkOutput("awburst", o_awburst, 1);
                    awAddrQ.push_back(o_awaddr);
                    awLenQ.push_back(o_awlen);
                end
                if (o_wvalid && o_wready) begin
                    if (awAddrQ.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL w_before_aw: got W beat 0x%0h with no AW, expected AW first", o_wdata);
                    end else begin
                        wQ.push_back('{aw: awAddrQ[0], len: awLenQ[0], data: o_wdata, strb: o_wstrb, last: o_wlast});
                        if (o_wlast) begin
                            void'(awAddrQ.pop_front());
                            void'(awLenQ.pop_front());
                            bPending = 1'b1;
                        end
                    end
                end
                if (i_bvalid && i_bready) begin
                    bPending = 1'b0;
                    bDone++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int   n;
        int   bBefore;
        vec_t v;

        resetn       = 1'b0;
        i_beat_valid = 1'b0;
        i_beat_addr  = '0;
        i_beat_data  = '0;
        i_beat_strb  = '0;

        // Four beats then idle: single flushed burst.
        addVec(12'h100, 12'h100, 8'd3, 0, 0, 0, 0);
        addVec(12'h104, 12'h100, 8'd3, 0, 0, 0, 1);
        addVec(12'h108, 12'h100, 8'd3, 0, 0, 0, 1);
        addVec(12'h10C, 12'h100, 8'd3, 1, 8, 0, 1);
        // Twenty contiguous beats: full burst then remainder.
        for (int i = 0; i < 20; i++)
            addVec(12'(i * 4), (i < 16) ? 12'h000 : 12'h040, (i < 16) ? 8'd15 : 8'd3,
                   (i == 15) || (i == 19), 0, 0, (i > 0) && (i < 16));
        // Address gap closes the burst; gap beat waits for B.
        addVec(12'h010, 12'h010, 8'd1, 0, 0, 0, 0);
        addVec(12'h014, 12'h010, 8'd1, 1, 0, 0, 1);
        addVec(12'h040, 12'h040, 8'd0, 1, 8, 1, 0);
        // Top of address space: never extended across the wrap.
        addVec(12'hFF8, 12'hFF8, 8'd1, 0, 0, 0, 0);
        addVec(12'hFFC, 12'hFF8, 8'd1, 1, 0, 0, 1);
        addVec(12'h000, 12'h000, 8'd0, 1, 8, 1, 0);

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_beat_ready", i_beat_ready, 0);
        checkOutput("rst_awvalid", o_awvalid, 0);
        checkOutput("rst_wvalid", o_wvalid, 0);
        checkOutput("rst_bready", i_bready, 0);
        checkOutput("rst_err", o_err, 0);
        checkOutput("rst_awaddr", o_awaddr, 0);
        checkOutput("rst_wdata", o_wdata, 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        n = 0;
        while ((wQ.size() < vecs.size() || bDone < 7) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #2;
        checkOutput("w_beat_count", wQ.size(), vecs.size());
        checkOutput("b_count", bDone, 7);
        for (int i = 0; i < vecs.size() && i < wQ.size(); i++) begin
            checkOutput($sformatf("beat%0d_awaddr", i), wQ[i].aw, vecs[i].expAw);
            checkOutput($sformatf("beat%0d_awlen", i), wQ[i].len, vecs[i].expLen);
            checkOutput($sformatf("beat%0d_wdata", i), wQ[i].data, vecs[i].data);
            checkOutput($sformatf("beat%0d_wstrb", i), wQ[i].strb, vecs[i].strb);
            checkOutput($sformatf("beat%0d_wlast", i), wQ[i].last, vecs[i].expLast);
        end
        checkOutput("err_after_slverr", o_err, 1);
        repeat (10) @(negedge clk);
        checkOutput("err_sticky", o_err, 1);

        // Reset while W is stalled mid-burst.
        holdW = 1'b1;
        applyStimulus(mkVec(12'h300, 12'h300, 8'd1, 0, 0, 0, 0), "pre_rst0");
        applyStimulus(mkVec(12'h304, 12'h300, 8'd1, 1, 1, 0, 1), "pre_rst1");
        n = 0;
        while (!o_wvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_send_w", o_wvalid, 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("midrst_awvalid", o_awvalid, 0);
        checkOutput("midrst_wvalid", o_wvalid, 0);
        checkOutput("midrst_bready", i_bready, 0);
        checkOutput("midrst_beat_ready", i_beat_ready, 0);
        checkOutput("midrst_err", o_err, 0);
        checkOutput("midrst_awaddr", o_awaddr, 0);
        checkOutput("midrst_awlen", o_awlen, 0);
        checkOutput("midrst_wdata", o_wdata, 0);
        awAddrQ.delete();
        awLenQ.delete();
        wQ.delete();
        bPending = 1'b0;
        holdW    = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        bBefore = bDone;
        v = mkVec(12'h200, 12'h200, 8'd0, 1, 1, 0, 1);
        applyStimulus(v, "post_rst");
        n = 0;
        while ((wQ.size() < 1 || bDone == bBefore) && n < 300) begin
            @(negedge clk);
            n++;
        end
        #2;
        checkOutput("post_rst_w_count", wQ.size(), 1);
        checkOutput("post_rst_b_count", bDone - bBefore, 1);
        if (wQ.size() > 0) begin
            checkOutput("post_rst_awaddr", wQ[0].aw, 12'h200);
            checkOutput("post_rst_awlen", wQ[0].len, 0);
            checkOutput("post_rst_wdata", wQ[0].data, v.data);
            checkOutput("post_rst_wlast", wQ[0].last, 1);
        end
        checkOutput("post_rst_err", o_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
